// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU sequencer, its program memory and the bench.
// The ALU opcode encodings here are the same ones the external ALU decodes.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int HALT_BIT = 15;

    localparam logic [2:0] OP_INC  = 3'b000;
    localparam logic [2:0] OP_DEC  = 3'b001;
    localparam logic [2:0] OP_NOT  = 3'b010;
    localparam logic [2:0] OP_MASK = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_ORLO = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

endpackage

// File: rtl/alu_seq_prog_mem.sv
// Program store for the ALU sequencer: DEPTH x 16 register array,
// one synchronous write port and one combinational read port.
module alu_seq_prog_mem #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    // NOTE: this array is built from flops, not a RAM macro, so it can and must
    // clear on reset; sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/alu_sequencer.sv
// Initiator for the external 16-bit combinational ALU: runs a stored program, one
// instruction per cycle, into an accumulator. Optional macro: INSTR_COUNT_EN.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter  int PROG_DEPTH = 8,
    localparam int AW         = $clog2(PROG_DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [15:0]   prog_data,
    input  logic          start,
    input  logic [15:0]   init_value,
    output logic [15:0]   alu_instruction,
    output logic [15:0]   alu_reg_in,
    input  logic [15:0]   alu_reg_out,
    output logic          busy,
    output logic          done,
    output logic [15:0]   result
`ifdef INSTR_COUNT_EN
    ,
    output logic [AW:0]   instr_count
`endif
);

    localparam logic [AW-1:0] LAST_PC = AW'(PROG_DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   acc_q, acc_d;
    logic [15:0]   prog_word;
    logic          idle;

    assign idle = (state_q == IDLE);

    // Writes are accepted only in IDLE, including the cycle a start is accepted.
    alu_seq_prog_mem #(
        .DEPTH (PROG_DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (prog_we && idle),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc_q),
        .rdata (prog_word)
    );

    // NOTE: every signal assigned here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = init_value;
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = alu_reg_out;
                if (prog_word[HALT_BIT] || (pc_q == LAST_PC)) begin
                    state_d = DONE;
                end else begin
                    pc_d = pc_q + AW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            acc_q   <= acc_d;
        end
    end

    assign alu_instruction = (state_q == RUN) ? prog_word : 16'h0000;
    assign alu_reg_in      = acc_q;
    assign busy            = !idle;
    assign done            = (state_q == DONE);
    assign result          = acc_q;

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (idle && start) begin
            instr_count <= '0;
        end else if (state_q == RUN) begin
            instr_count <= instr_count + (AW+1)'(1);
        end
    end
`endif

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Drives the instruction/operand side of the 16-bit ALU interface and captures its result, i.e. the initiator for the ALU's combinational responder. It holds a small loadable program of 16-bit instruction words and an accumulator. On start it steps through the program, one instruction per cycle: it presents the instruction and the accumulator to the ALU, then writes the ALU result back into the accumulator. The ALU itself stays external; this block sits between the lab control logic and the ALU.

Parameters:
PROG_DEPTH, 8, number of program words; power of two, 2..256.
AW, $clog2(PROG_DEPTH), program address width (derived, not overridden).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
prog_we  input  1  program write strobe; ignored while busy=1.
prog_addr  input  AW  program write address.
prog_data  input  16  program write data.
start  input  1  one-cycle pulse; begins a run from address 0; ignored unless state is IDLE.
init_value  input  16  accumulator load value, sampled on the accepted start.
alu_instruction  output  16  instruction to the ALU; opcode is bits [2:0].
alu_reg_in  output  16  operand to the ALU; always equals the accumulator.
alu_reg_out  input  16  ALU result; combinational from alu_instruction and alu_reg_in.
busy  output  1  high in RUN and DONE.
done  output  1  one-cycle pulse when a run completes.
result  output  16  accumulator value; stable whenever busy=0.

Behaviour:
- Instruction word: bits [2:0] are the ALU opcode. Bit [15] is HALT. Bits [14:3] are reserved, passed through unchanged, and have no meaning here.
- Reset (async assert, sync deassert by the system): state=IDLE, pc=0, acc=0, program array=0, busy=0, done=0, result=0.
- The program array is registered storage with a combinational read. A write happens on a clock edge when prog_we=1 and state=IDLE.
- alu_instruction = prog[pc] in RUN; 16'h0000 in IDLE and DONE.
- alu_reg_in = acc at all times.
- States:
  - IDLE: on start, set acc<=init_value and pc<=0, then go to RUN. start and prog_we in the same cycle: the write is performed and the run begins, so the new word is visible at pc=0 only if prog_addr=0.
  - RUN: every cycle, acc<=alu_reg_out. If prog[pc][15]=1 or pc==PROG_DEPTH-1, go to DONE with pc held. Otherwise pc<=pc+1. The HALT-flagged instruction executes before the sequencer stops.
  - DONE: done=1 for exactly this cycle, then go to IDLE.
- Latency: a program of N executed instructions gives N RUN cycles plus 1 DONE cycle. done is asserted N+1 cycles after the start edge.
- pc never wraps. Reaching the last address ends the run even without HALT.
- start while busy=1 is ignored and not queued. prog_we while busy=1 is dropped.
- Reset mid-run aborts immediately to the reset values, including clearing the program array.
- Arithmetic is entirely inside the ALU. This block does no width extension and uses no carry.

Optional Feature:
INSTR_COUNT_EN:
- Defined: adds output instr_count [AW:0]. It clears to 0 on reset and on an accepted start, increments once per RUN cycle, and holds after DONE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum typedef (IDLE, RUN, DONE);
  - localparam HALT_BIT = 15;
  - ALU opcode localparams OP_INC=3'b000, OP_DEC, OP_NOT, OP_MASK, OP_SHL, OP_SHR, OP_ORLO, OP_CLR=3'b111, shared with the ALU and the bench.
- One natural sub-module, alu_seq_prog_mem: the PROG_DEPTH x 16 register array with one write port and one combinational read port.

Test Plan:
- Load [0]=16'h0000, [1]=16'h0000, [2]=16'h8000; init 5; start -> three RUN cycles, done on cycle 4, result=16'h0008.
- Load [0]=16'h0004, [1]=16'h0004, [2]=16'h8005; init 16'h0003 -> result=16'h0006 (<<1, <<1, >>1).
- Load [0]=16'h0002, [1]=16'h8003; init 16'h1234 -> NOT gives 16'hEDCB, then AND 16'h0FFF gives result=16'h0DCB.
- No HALT anywhere: PROG_DEPTH=8, all words 16'h0000, init 0 -> 8 RUN cycles, result=16'h0008, pc stops at 7 without wrapping.
- start and prog_we pulsed mid-run -> both ignored; busy stays high; program memory is unchanged when read back on the next run.
- rst_n dropped mid-run -> next cycle shows busy=0, result=0; a subsequent start with the program reloaded runs normally. With INSTR_COUNT_EN defined, instr_count matches the RUN cycle count in every scenario.
